// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the ID-stage hazard controller: MIPS opcode/funct
// constants, the halt word, controller state encoding, the shadow
// scoreboard slot and the decoded-instruction record.
package hazard_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Width of the drain countdown register
  localparam int DRAIN_W = 16;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } shadow_slot_t;

  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       has_dest;
    logic [4:0] dest;
    logic       is_load;
    logic       is_halt;
  } id_decode_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Control bundle between the ID stage and the hazard controller.
//   master: pipeline side, drives id_instruction/branch_taken, receives controls
//   slave : hazard controller, receives instruction/branch, drives controls
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instruction;
  logic             branch_taken;
  logic             control_mux;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_instruction, branch_taken,
    input  control_mux, pc_write, if_id_write, if_id_flush, id_ex_flush,
           halted, stall_count
  );

  modport slave (
    input  id_instruction, branch_taken,
    output control_mux, pc_write, if_id_write, if_id_flush, id_ex_flush,
           halted, stall_count
  );
endinterface

// File: rtl/hazard_controller_decode.sv
// hazard_decode: purely combinational register-usage decode of one MIPS
// instruction. Ports:
//   instruction : 32-bit instruction word
//   dec         : {uses_rs, uses_rt, rs, rt, has_dest, dest, is_load, is_halt}
// A destination of $0 is reported as "no destination" so it can never hazard.
module hazard_decode
  import hazard_controller_pkg::*;
(
  input  logic [31:0] instruction,
  output id_decode_t  dec
);

  logic [5:0] op;
  logic [5:0] fn;

  always_comb begin
    op  = instruction[31:26];
    fn  = instruction[5:0];
    dec = '0;

    dec.rs      = instruction[25:21];
    dec.rt      = instruction[20:16];
    dec.uses_rs = !((op == OP_RTYPE) &&
                    ((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA)));
    dec.uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) ||
                  (op == OP_BNE)   || (op == OP_SW);

    if ((op == OP_RTYPE) && (fn != FN_JR)) begin
      dec.has_dest = 1'b1;
      dec.dest     = instruction[15:11];
    end else if ((op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
                 (op == OP_ORI)  || (op == OP_XORI)  || (op == OP_LW)) begin
      dec.has_dest = 1'b1;
      dec.dest     = instruction[20:16];
    end
    if (dec.dest == 5'd0) dec.has_dest = 1'b0;

    dec.is_load = (op == OP_LW);
    dec.is_halt = (instruction == HALT_WORD);
  end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage pipeline sequencer for the 5-stage MIPS core.
// Tracks in-flight destinations in EX/MEM shadow slots, stalls on RAW or
// load-use hazards, flushes on taken branches and drains on the halt word.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous active-high reset; all outputs forced 0 while high
//   hz    : slave side of hazard_controller_if (instruction, branch_taken,
//           control_mux, pc_write, if_id_write, flushes, halted, stall_count)
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int FORWARDING   = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_controller_if.slave hz
);

  hz_state_e          state, state_nxt;
  shadow_slot_t       ex_slot, mem_slot, id_slot;
  id_decode_t         dec;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               hit_ex, hit_mem, hazard;
  logic               in_run, flush, halt_go, stall, issue;

  hazard_decode u_decode (
    .instruction (hz.id_instruction),
    .dec         (dec)
  );

  always_comb begin
    hit_ex  = ex_slot.valid &&
              ((dec.uses_rs && (ex_slot.dest == dec.rs)) ||
               (dec.uses_rt && (ex_slot.dest == dec.rt)));
    hit_mem = mem_slot.valid &&
              ((dec.uses_rs && (mem_slot.dest == dec.rs)) ||
               (dec.uses_rt && (mem_slot.dest == dec.rt)));
    hazard  = (FORWARDING != 0) ? (hit_ex && ex_slot.is_load) : (hit_ex || hit_mem);

    // Priority: branch > halt > hazard; only meaningful in RUN
    in_run  = (state == RUN);
    flush   = in_run && hz.branch_taken;
    halt_go = in_run && !hz.branch_taken && dec.is_halt;
    stall   = in_run && !hz.branch_taken && !dec.is_halt && hazard;
    issue   = in_run && !hz.branch_taken && !dec.is_halt && !hazard;

    id_slot         = '0;
    id_slot.valid   = dec.has_dest;
    id_slot.dest    = dec.dest;
    id_slot.is_load = dec.is_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // The entry edge counts as the first drain edge, so halted rises exactly
  // DRAIN_CYCLES edges after the halt word is seen in ID.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (halt_go) state_nxt = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
      DRAIN:   if (drain_cnt <= DRAIN_W'(1)) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= issue ? id_slot : '0;
      if (halt_go)
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      else if (state == DRAIN)
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    hz.control_mux = 1'b0;
    hz.pc_write    = 1'b0;
    hz.if_id_write = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.halted      = 1'b0;
    hz.stall_count = '0;
    if (!reset) begin
      hz.stall_count = stall_cnt;
      if (flush) begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
      end else if (issue) begin
        hz.control_mux = 1'b1;
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
      end
      hz.halted = (state == HALTED);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed self-checking bench for hazard_controller. Two DUTs
// (FORWARDING=1 and FORWARDING=0) see identical stimulus; a timeline model
// records what issued on each cycle and derives the expected controls.
module tb_hazard_controller;

  localparam int DRAIN = 4;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(16)) hz1 ();
  hazard_controller_if #(.CNT_W(16)) hz0 ();

  hazard_controller #(.FORWARDING(1), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut_fwd (
    .clk(clk), .reset(reset), .hz(hz1));
  hazard_controller #(.FORWARDING(0), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut_nofwd (
    .clk(clk), .reset(reset), .hz(hz0));

  // index d == FORWARDING value of that DUT
  logic [5:0]  act[2];
  logic [15:0] act_cnt[2];
  assign act[1] = {hz1.control_mux, hz1.pc_write, hz1.if_id_write,
                   hz1.if_id_flush, hz1.id_ex_flush, hz1.halted};
  assign act[0] = {hz0.control_mux, hz0.pc_write, hz0.if_id_write,
                   hz0.if_id_flush, hz0.id_ex_flush, hz0.halted};
  assign act_cnt[1] = hz1.stall_count;
  assign act_cnt[0] = hz0.stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model state: per-cycle issue record, halt cycle, stall count
  int          cyc;
  int          iss_dst[2][MAXC];
  bit          iss_ld[2][MAXC];
  int          halt_at[2];
  int unsigned scnt[2];

  function automatic void tb_dec(input logic [31:0] w, output int s1, output int s2,
                                 output int dst, output bit ld);
    int op, fn, rs, rt, rd;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    s1 = (op == 0 && (fn == 0 || fn == 2 || fn == 3)) ? -1 : rs;
    s2 = (op == 0 || op == 4 || op == 5 || op == 43) ? rt : -1;
    dst = -1;
    if (op == 0 && fn != 8) dst = rd;
    else if (op == 8 || op == 9 || op == 12 || op == 13 || op == 14 || op == 35) dst = rt;
    if (dst == 0) dst = -1;
    if (s1 == 0) s1 = -1;
    if (s2 == 0) s2 = -1;
    ld = (op == 35);
  endfunction

  function automatic bit hits(input int p, input int s1, input int s2);
    return (p >= 0) && ((p == s1) || (p == s2));
  endfunction

  task automatic step(input logic [31:0] ins, input bit br);
    int s1, s2, dst, p1, p2;
    bit ld, l1, hzd, skip_ifw;
    int e_dst[2];
    bit e_ld[2], e_inc[2], e_halt[2];
    logic [5:0] e;
    string nm[6];
    nm = '{"control_mux", "pc_write", "if_id_write", "if_id_flush", "id_ex_flush", "halted"};
    hz1.id_instruction = ins; hz0.id_instruction = ins;
    hz1.branch_taken   = br;  hz0.branch_taken   = br;
    #2;
    tb_dec(ins, s1, s2, dst, ld);
    for (int d = 0; d < 2; d++) begin
      e_dst[d] = -1; e_ld[d] = 1'b0; e_inc[d] = 1'b0; e_halt[d] = 1'b0;
      skip_ifw = 1'b0;
      p1 = (cyc >= 1) ? iss_dst[d][cyc-1] : -1;
      l1 = (cyc >= 1) ? iss_ld[d][cyc-1]  : 1'b0;
      p2 = (cyc >= 2) ? iss_dst[d][cyc-2] : -1;
      hzd = (d == 1) ? (l1 && hits(p1, s1, s2)) : (hits(p1, s1, s2) || hits(p2, s1, s2));
      if (halt_at[d] >= 0) begin
        e = {5'b0, (cyc >= halt_at[d] + DRAIN)};
      end else if (br) begin
        e = 6'b010110;
        skip_ifw = 1'b1;
      end else if (ins == 32'hFFFF_FFFF) begin
        e = 6'b0;
        e_halt[d] = 1'b1;
      end else if (hzd) begin
        e = 6'b0;
        e_inc[d] = 1'b1;
      end else begin
        e = 6'b111000;
        e_dst[d] = dst; e_ld[d] = ld;
      end
      for (int b = 0; b < 6; b++)
        if (!(skip_ifw && b == 2))
          check_val($sformatf("c%0d f%0d %s", cyc, d, nm[b]), 32'(act[d][5-b]), 32'(e[5-b]));
      check_val($sformatf("c%0d f%0d stall_count", cyc, d), 32'(act_cnt[d]), scnt[d]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      iss_dst[d][cyc] = e_dst[d];
      iss_ld[d][cyc]  = e_ld[d];
      if (e_halt[d]) halt_at[d] = cyc;
      if (e_inc[d] && scnt[d] < 32'hFFFF) scnt[d]++;
    end
    if (cyc < MAXC - 1) cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("rst f%0d outputs", d), 32'(act[d]), 32'd0);
      check_val($sformatf("rst f%0d stall_count", d), 32'(act_cnt[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      halt_at[d] = -1;
      scnt[d] = 0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 8))
      0: return {6'h00, a, b, c, 5'd0, 6'h20};
      1: return {6'h00, a, b, c, 5'($urandom_range(0, 31)), 6'h00};
      2: return {6'h00, a, 5'd0, 5'd0, 5'd0, 6'h08};
      3: return {6'h23, a, b, 16'($urandom)};
      4: return {6'h2B, a, b, 16'($urandom)};
      5: return {6'h04, a, b, 16'($urandom)};
      6: return {6'h08, a, b, 16'($urandom)};
      7: return {6'h0D, a, b, 16'($urandom)};
      default: return {6'h02, 26'($urandom)};
    endcase
  endfunction

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  localparam logic [31:0] LW9      = {6'h23, 5'd8, 5'd9, 16'd0};
  localparam logic [31:0] LW0      = {6'h23, 5'd8, 5'd0, 16'd0};
  localparam logic [31:0] ADD_99   = {6'h00, 5'd9, 5'd9, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADD_00   = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADD_90   = {6'h00, 5'd9, 5'd0, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADDI11   = {6'h08, 5'd0, 5'd11, 16'd3};
  localparam logic [31:0] ADDI9    = {6'h08, 5'd0, 5'd9, 16'd5};
  localparam logic [31:0] SLL_RT9  = {6'h00, 5'd0, 5'd9, 5'd10, 5'd2, 6'h00};
  localparam logic [31:0] SLL_RS9  = {6'h00, 5'd9, 5'd3, 5'd10, 5'd2, 6'h00};

  initial begin
    hz1.id_instruction = NOP; hz0.id_instruction = NOP;
    hz1.branch_taken = 1'b0;  hz0.branch_taken = 1'b0;
    #3;
    do_reset();

    // load-use: one bubble with forwarding, two without
    step(LW9, 0); step(ADD_99, 0); step(ADD_99, 0); step(ADD_99, 0); step(NOP, 0);
    check_val("tp1 fwd count", 32'(hz1.stall_count), 32'd1);
    check_val("tp1 nofwd count", 32'(hz0.stall_count), 32'd2);

    do_reset();
    step(LW9, 0); step(ADDI11, 0); step(LW0, 0); step(ADD_00, 0); step(NOP, 0);
    check_val("tp2 fwd count", 32'(hz1.stall_count), 32'd0);

    do_reset();
    step(ADDI9, 0); step(ADD_90, 0); step(ADD_90, 0); step(ADD_90, 0);
    step(ADDI9, 0); step(SLL_RT9, 0); step(SLL_RT9, 0); step(SLL_RT9, 0);
    step(ADDI9, 0); step(SLL_RS9, 0); step(NOP, 0);
    check_val("tp3 nofwd count", 32'(hz0.stall_count), 32'd4);
    check_val("tp3 fwd count", 32'(hz1.stall_count), 32'd0);

    do_reset();
    step(LW9, 0); step(ADD_99, 1); step(NOP, 0);
    check_val("tp4 fwd count", 32'(hz1.stall_count), 32'd0);

    do_reset();
    step(LW9, 0); step(ADD_99, 0); step(ADD_99, 0); step(ADD_99, 0);
    step(HALT, 0);
    for (int i = 0; i < 14; i++) step(NOP, (i % 3) == 0);
    check_val("tp5 halted", 32'(hz1.halted), 32'd1);

    do_reset();
    step(LW9, 0); step(ADD_99, 0); step(ADD_99, 0); step(HALT, 0);
    step(NOP, 0); step(NOP, 0);
    do_reset();
    check_val("tp6 halted", 32'(hz1.halted), 32'd0);
    step(ADDI11, 0);
    check_val("tp6 pc issued", 32'(hz1.stall_count), 32'd0);

    for (int ep = 0; ep < 5; ep++) begin
      do_reset();
      for (int i = 0; i < 80; i++)
        step(($urandom_range(0, 49) == 0) ? HALT : rand_instr(), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
